// File: rtl/dt_pkg.sv
// dt_pkg: shared constants, scanner state encoding and helpers for the distance-transform blocks.
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 15;
    localparam int ROW_LEN = 128;
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} scan_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/dt_max_tracker.sv
// dt_max_tracker: running maximum, first-occurrence address, tie count and foreground count.
module dt_max_tracker
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr,
    output logic [CNT_W-1:0]  max_count,
    output logic [CNT_W-1:0]  fg_count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            max_val   <= '0;
            max_addr  <= '0;
            max_count <= '0;
            fg_count  <= '0;
        end else if (valid) begin
            // strict compare keeps the first raster occurrence on ties
            if (d > max_val) begin
                max_val   <= d;
                max_addr  <= a;
                max_count <= CNT_W'(1);
            end else if (d == max_val) begin
                max_count <= sat_inc(max_count);
            end
            if (d != '0) fg_count <= sat_inc(fg_count);
        end
    end
endmodule

// File: rtl/dt_result_scanner.sv
// dt_result_scanner: streams the DT result RAM once per start and reports max/first-address/tie/foreground statistics.
module dt_result_scanner
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              res_rd,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [DATA_W-1:0] res_di,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr,
    output logic [CNT_W-1:0]  max_count,
    output logic [CNT_W-1:0]  fg_count
);
    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt, a_q;
    logic              vld, clear;

    assign clear = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (cnt == LAST_ADDR) ? FLUSH : SCAN;
            FLUSH:   state_d = DONE;
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            vld     <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            vld     <= state_q == SCAN;
            a_q     <= cnt;
            cnt     <= clear ? '0 : (state_q == SCAN && cnt != LAST_ADDR) ? cnt + 1'b1 : cnt;
        end
    end

    assign res_rd   = state_q == SCAN;
    assign res_addr = res_rd ? cnt : '0;
    assign busy     = (state_q == SCAN) || (state_q == FLUSH);
    assign done     = state_q == DONE;

    dt_max_tracker u_trk (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .valid     (vld),
        .d         (res_di),
        .a         (a_q),
        .max_val   (max_val),
        .max_addr  (max_addr),
        .max_count (max_count),
        .fg_count  (fg_count)
    );
endmodule

// File: tb/tb_dt_result_scanner.sv
// tb_dt_result_scanner: RAM model, timeline model and image statistics model checked every cycle against the scanner.
module tb_dt_result_scanner;
    import dt_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start;
    logic              res_rd, busy, done;
    logic [ADDR_W-1:0] res_addr, max_addr;
    logic [DATA_W-1:0] res_di, max_val;
    logic [CNT_W-1:0]  max_count, fg_count;

    dt_result_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .busy      (busy),
        .done      (done),
        .max_val   (max_val),
        .max_addr  (max_addr),
        .max_count (max_count),
        .fg_count  (fg_count)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [NPIX];
    always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

    int total = 0, bad = 0;
    int e_max, e_addr, e_cnt, e_fg;
    int n = 0, rd_cnt = 0;
    bit act = 0, dn = 0, chk_en = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // statistics straight from the image: maximum, first index holding it, how many hold it, nonzero count
    task automatic compute_expected();
        e_max = 0; e_fg = 0; e_cnt = 0; e_addr = -1;
        for (int i = 0; i < NPIX; i++) if (int'(mem[i]) > e_max) e_max = int'(mem[i]);
        for (int i = 0; i < NPIX; i++) begin
            if (int'(mem[i]) == e_max) begin
                e_cnt++;
                if (e_addr < 0) e_addr = i;
            end
            if (mem[i] != 0) e_fg++;
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'(v);
    endtask

    // timeline: n counts edges since start was taken; reads for n<NPIX, flush at NPIX, done after
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            act = 0; dn = 0; n = 0;
        end else if (!act && !dn && start) begin
            act = 1; n = 0;
        end else if (act) begin
            n++;
            if (n == NPIX + 1) begin act = 0; dn = 1; end
        end else if (dn && !start) dn = 0;
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            chk("res_rd", res_rd, act && n < NPIX);
            chk("res_addr", res_addr, (act && n < NPIX) ? n : 0);
            chk("busy", busy, act);
            chk("done", done, dn);
            if (dn) begin
                chk("max_val", max_val, e_max);
                chk("max_addr", max_addr, e_addr);
                chk("max_count", max_count, e_cnt);
                chk("fg_count", fg_count, e_fg);
            end
            if (res_rd) rd_cnt++;
        end
    end

    task automatic wait_done();
        for (int k = 0; k < NPIX + 100 && !done; k++) @(negedge clk);
        chk("done_timeout", done, 1);
    endtask

    task automatic chk_lit(input int v, input int a, input int c, input int f);
        chk("lit_max_val", max_val, v);
        chk("lit_max_addr", max_addr, a);
        chk("lit_max_count", max_count, c);
        chk("lit_fg_count", fg_count, f);
    endtask

    task automatic run_scan();
        compute_expected();
        @(negedge clk) start = 1;
        wait_done();
    endtask

    task automatic finish_scan();
        start = 0;
        repeat (2) @(negedge clk);
        chk("idle_done_low", done, 0);
    endtask

    initial begin
        reset = 1; start = 0;
        fill(0);
        repeat (3) @(negedge clk);
        chk_lit(0, 0, 0, 0);
        chk("reset_rd", res_rd, 0);
        chk("reset_done", done, 0);
        reset = 0; chk_en = 1;

        // all-zero image with start held: exactly one scan, done stays up
        compute_expected();
        rd_cnt = 0;
        @(negedge clk) start = 1;
        repeat (20000) @(negedge clk);
        chk("hold_reads", rd_cnt, NPIX);
        chk("hold_done", done, 1);
        chk_lit(0, 0, NPIX, 0);
        finish_scan();

        // abort mid-scan with reset, start pulsed only one cycle
        fill(0); mem[300] = 7; mem[9000] = 7; mem[50] = 3;
        compute_expected();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        repeat (4999) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        reset = 1;
        #1;
        chk("abort_rd", res_rd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", res_addr, 0);
        chk_lit(0, 0, 0, 0);
        @(negedge clk) reset = 0;
        rd_cnt = 0;
        run_scan();
        chk("restart_reads", rd_cnt, NPIX);
        chk_lit(7, 300, 2, 3);
        finish_scan();

        // final pixel only reaches the tracker during flush
        fill(1); mem[NPIX-1] = 255;
        run_scan();
        chk_lit(255, NPIX - 1, 1, NPIX);
        finish_scan();

        fill(0); mem[200] = 5;
        run_scan();
        chk_lit(5, 200, 1, 1);
        finish_scan();

        // random sparse image with frequent ties
        for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 20)) : '0;
        mem[0] = '0;
        run_scan();
        finish_scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
